// File: rtl/hc165_shifter.sv
// 74HC165-style parallel-in / serial-out shifter: load 8 bits on Start, shift MSB first on Ce.
// Define HC165_CASCADE_EN to fill bit 0 from DS so several devices can be chained Q7 -> DS.
module hc165_shifter (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] D,
  input  logic       Ce,
  input  logic       DS,
  output logic       Q7,
  output logic       Q7N,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fill;

`ifdef HC165_CASCADE_EN
  assign fill = DS;
`else
  // DS stays on the port so cascaded and standalone builds share one footprint.
  logic unused_ds;
  assign unused_ds = DS;
  assign fill      = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sr_q    <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          sr_d    = D;
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (Ce) begin
          sr_d  = {sr_q[6:0], fill};
          cnt_d = cnt_q + 3'd1;
          // Counter wraps to 0 on the eighth shift, which ends the frame.
          if (cnt_q == 3'd7) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A Start here chains the next frame with no idle gap.
        if (Start) begin
          sr_d    = D;
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    Q7   = sr_q[7];
    Q7N  = ~sr_q[7];
    Busy = (state_q == S_SHIFT);
    Done = (state_q == S_DONE);
  end

endmodule
